// File: rtl/branch_resolve_unit.sv
// Purpose: branch resolution stage. Decides taken/not-taken and the next PC for one
//          conditional-branch uop, flags mispredicts and counts them (saturating).
// Latency: 1 cycle, accept to out_valid. Backpressure: a single output register;
//          in_ready drops while a result is held and out_ready is low, or during a flush.
//
// Ports:
//   clk, rst_n           clock and asynchronous active-low reset
//   flush                kills the held result and blocks accept this cycle
//   in_*                 uop operands, PC, offset, prediction and ROB tag (valid/ready)
//   out_*                registered resolution result (valid/ready)
//   mispredict_count     saturating count of delivered mispredicts

// 32-bit equality comparator shared with the rest of the execute cluster.
module cmp32 (
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    output logic        eq_o
);
    assign eq_o = (a_i == b_i);
endmodule

module branch_resolve_unit #(
    parameter int ROB_W = 5,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_funct3,
    input  logic [31:0]      in_rs1,
    input  logic [31:0]      in_rs2,
    input  logic [31:0]      in_pc,
    input  logic [31:0]      in_imm,
    input  logic             in_pred_taken,
    input  logic [ROB_W-1:0] in_rob_id,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ROB_W-1:0] out_rob_id,
    output logic             out_taken,
    output logic [31:0]      out_target,
    output logic             out_mispredict,
    output logic             out_illegal,
    output logic [CNT_W-1:0] mispredict_count
);

    localparam logic [2:0] F_BEQ  = 3'b000;
    localparam logic [2:0] F_BNE  = 3'b001;
    localparam logic [2:0] F_BLT  = 3'b100;
    localparam logic [2:0] F_BGE  = 3'b101;
    localparam logic [2:0] F_BLTU = 3'b110;
    localparam logic [2:0] F_BGEU = 3'b111;

    logic             valid_q,   valid_d;
    logic [ROB_W-1:0] rob_id_q;
    logic             taken_q,   taken_d;
    logic [31:0]      target_q,  target_d;
    logic             mispred_q, mispred_d;
    logic             illegal_q, illegal_d;
    logic [CNT_W-1:0] cnt_q,     cnt_d;

    logic eq;
    logic lt_s;
    logic lt_u;
    logic accept;
    logic deliver;

    cmp32 u_cmp (
        .a_i  (in_rs1),
        .b_i  (in_rs2),
        .eq_o (eq)
    );

    assign lt_s = $signed(in_rs1) < $signed(in_rs2);
    assign lt_u = in_rs1 < in_rs2;

    // Ready only looks at the output slot and flush, never at in_valid.
    assign in_ready = !flush && (!valid_q || out_ready);
    assign accept   = in_valid && in_ready;
    // A transfer coinciding with a flush is discarded and does not count.
    assign deliver  = valid_q && out_ready && !flush;

    always_comb begin
        taken_d   = 1'b0;
        illegal_d = 1'b0;
        case (in_funct3)
            F_BEQ:   taken_d = eq;
            F_BNE:   taken_d = !eq;
            F_BLT:   taken_d = lt_s;
            F_BGE:   taken_d = !lt_s;
            F_BLTU:  taken_d = lt_u;
            F_BGEU:  taken_d = !lt_u;
            default: illegal_d = 1'b1;  // 010/011: forced not-taken
        endcase
        // Plain 32-bit adds; wrap-around past 0xFFFF_FFFF is intended.
        target_d  = taken_d ? (in_pc + in_imm) : (in_pc + 32'd4);
        mispred_d = taken_d ^ in_pred_taken;
    end

    always_comb begin
        valid_d = valid_q;
        if (flush) begin
            valid_d = 1'b0;
        end else if (accept) begin
            valid_d = 1'b1;
        end else if (out_ready) begin
            valid_d = 1'b0;
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (deliver && mispred_q && !(&cnt_q)) begin
            cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q   <= 1'b0;
            rob_id_q  <= '0;
            taken_q   <= 1'b0;
            target_q  <= '0;
            mispred_q <= 1'b0;
            illegal_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            valid_q <= valid_d;
            cnt_q   <= cnt_d;
            // Payload only moves on accept, so it stays frozen under backpressure.
            if (accept) begin
                rob_id_q  <= in_rob_id;
                taken_q   <= taken_d;
                target_q  <= target_d;
                mispred_q <= mispred_d;
                illegal_q <= illegal_d;
            end
        end
    end

    assign out_valid        = valid_q;
    assign out_rob_id       = rob_id_q;
    assign out_taken        = taken_q;
    assign out_target       = target_q;
    assign out_mispredict   = mispred_q;
    assign out_illegal      = illegal_q;
    assign mispredict_count = cnt_q;

endmodule

// File: doc/branch_resolve_unit.md
Name: branch_resolve_unit

Overview:
- Single-entry pipelined branch resolution stage in the execute cluster; consumes the 32-bit equality result of a cmp32 instance, plus in-block signed/unsigned less-than.
- Accepts one conditional-branch uop per cycle, decides taken/not-taken and the target, flags mispredicts against the front-end prediction, and hands the result to the ROB/redirect logic over a valid/ready handshake.
- Keeps a saturating mispredict counter for perf monitoring.

Parameters:
- ROB_W, 5, width of ROB index carried with each uop
- CNT_W, 16, width of mispredict counter

Ports:
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- flush  in  1  pipeline flush; kills accepted and pending uops
- in_valid  in  1  upstream uop valid
- in_ready  out  1  stage can accept this cycle
- in_funct3  in  3  branch type: 000 BEQ, 001 BNE, 100 BLT, 101 BGE, 110 BLTU, 111 BGEU
- in_rs1  in  32  operand A
- in_rs2  in  32  operand B
- in_pc  in  32  branch PC
- in_imm  in  32  sign-extended B-type offset
- in_pred_taken  in  1  front-end prediction
- in_rob_id  in  ROB_W  ROB tag
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts
- out_rob_id  out  ROB_W  tag of result
- out_taken  out  1  resolved direction
- out_target  out  32  next PC: taken ? pc+imm : pc+4
- out_mispredict  out  1  out_taken != pred_taken
- out_illegal  out  1  funct3 was 010 or 011
- mispredict_count  out  CNT_W  saturating mispredict count

Behaviour:
- Reset (async, rst_n low): out_valid=0, out_rob_id=0, out_taken=0, out_target=0, out_mispredict=0, out_illegal=0, mispredict_count=0. Reset asserted mid-transfer drops the pending result immediately.
- in_ready = !flush && (!out_valid || out_ready). Combinational; no dependency on in_valid.
- Accept on in_valid && in_ready. Result registered; out_valid rises the cycle after accept (latency 1).
- Output register holds all out_* stable while out_valid && !out_ready.
- Back-to-back: handshake on both sides in the same cycle replaces the entry; no bubble.
- out_valid falls after out_valid && out_ready with no new accept.
- Condition:
  - eq from cmp32(rs1, rs2)
  - BEQ=eq, BNE=!eq
  - BLT=signed rs1<rs2, BGE=!BLT
  - BLTU=unsigned rs1<rs2, BGEU=!BLTU
- funct3 010/011: out_taken=0, out_illegal=1, out_mispredict=in_pred_taken, target=pc+4.
- Target arithmetic: 32-bit, wraps modulo 2^32 (0xFFFF_FFFC+4 = 0x0000_0000). No alignment check.
- Flush:
  - Next cycle out_valid=0. The pending result is discarded, even if out_ready was high during the flush cycle.
  - No accept during the flush cycle.
  - Counter does not increment for a transfer in the flush cycle.
- mispredict_count increments by 1 on out_valid && out_ready && out_mispredict && !flush. Holds at all-ones.
- No other internal state.

Test Plan:
- Reset: rst_n low mid-cycle with out_valid=1 -> all outputs 0 immediately, in_ready=1 after release.
- BEQ rs1=rs2=0xAAAA_AAAA, pc=0x100, imm=0x20, pred=0, out_ready=1 -> next cycle out_valid=1, taken=1, target=0x120, mispredict=1; count 0->1 on that handshake.
- Signed vs unsigned: rs1=0xFFFF_FFFF, rs2=1 -> BLT taken=1, BLTU taken=0, BGEU taken=1, BNE taken=1. BEQ with rs2=0xBBBB_BBBB -> taken=0, target=pc+4.
- Backpressure: out_ready=0 three cycles after accept -> outputs stable, in_ready=0, new in_valid ignored. Then out_ready=1 with in_valid=1 -> simultaneous drain+accept, second result next cycle.
- Flush: flush=1 while out_valid=1, out_ready=1, mispredict=1 -> out_valid=0 next cycle, count unchanged, in_ready=0 in the flush cycle.
- Wrap/saturation/illegal:
  - pc=0xFFFF_FFFC not-taken -> target 0x0.
  - funct3=010, pred=1 -> illegal=1, mispredict=1.
  - CNT_W=2: four mispredicts -> count stays 3.
